// File: rtl/prefetch_data_queue.sv
// Circular promise/data queue sitting behind the prefetcher controller.
// Entries move through three stages: pushed (address known), promised
// (claimed by a master lookup) and filled (data returned from memory).
// Four wrap-bit pointers track the stages:
//   head <= promPtr <= tail
//   head <= dataPtr <= tail
module prefetch_data_queue #(
  parameter int ADDR_BITS            = 64,
  parameter int LOG_QUEUE_SIZE       = 6,
  parameter int LOG_BLOCK_DATA_BYTES = 6,
  parameter int ALMOST_FULL_MARGIN   = 2
) (
  input  logic                                  clk,
  input  logic                                  resetN,
  input  logic                                  en,
  input  logic                                  dataFlushN,
  input  logic [2:0]                            pr_opCode,
  input  logic [ADDR_BITS-1:0]                  pr_addr,
  input  logic                                  pr_r_out_last,
  input  logic [(8<<LOG_BLOCK_DATA_BYTES)-1:0]  pr_r_out_data,
  output logic                                  pr_addrHit,
  output logic                                  pr_r_valid,
  output logic                                  pr_r_in_last,
  output logic [(8<<LOG_BLOCK_DATA_BYTES)-1:0]  pr_r_in_data,
  output logic                                  pr_hasOutstanding,
  output logic [LOG_QUEUE_SIZE:0]               prefetchReqCnt,
  output logic                                  almostFull,
  output logic                                  protoErr
);

  localparam int D  = 1 << LOG_QUEUE_SIZE;
  localparam int PW = LOG_QUEUE_SIZE + 1;
  localparam int BW = 8 << LOG_BLOCK_DATA_BYTES;

  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_PREF    = 3'd1;
  localparam logic [2:0] OP_MASTER  = 3'd2;
  localparam logic [2:0] OP_SLAVE   = 3'd3;
  localparam logic [2:0] OP_PROMISE = 3'd4;

  localparam logic [PW-1:0] FULL_CNT  = PW'(D);
  localparam logic [PW-1:0] AF_THRESH = PW'(D - ALMOST_FULL_MARGIN);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);

  // Clears the in-block offset so lookups match on whole blocks.
  localparam logic [ADDR_BITS-1:0] BLK_MASK =
    {{(ADDR_BITS-LOG_BLOCK_DATA_BYTES){1'b1}}, {LOG_BLOCK_DATA_BYTES{1'b0}}};

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] prom_q, prom_d;
  logic [PW-1:0] data_q, data_d;
  logic [PW-1:0] tail_q, tail_d;
  logic          err_q,  err_d;

  logic                 push_we;
  logic                 fill_we;
  logic [PW-1:0]        count;
  logic                 full;
  logic                 empty;
  logic [ADDR_BITS-1:0] lookup_blk;

  // Storage has no reset: it is only read through pointers that are reset.
  logic [ADDR_BITS-1:0] addr_mem [D];
  logic [BW-1:0]        data_mem [D];
  logic                 last_mem [D];

  wire [LOG_QUEUE_SIZE-1:0] head_idx = head_q[LOG_QUEUE_SIZE-1:0];
  wire [LOG_QUEUE_SIZE-1:0] prom_idx = prom_q[LOG_QUEUE_SIZE-1:0];
  wire [LOG_QUEUE_SIZE-1:0] data_idx = data_q[LOG_QUEUE_SIZE-1:0];
  wire [LOG_QUEUE_SIZE-1:0] tail_idx = tail_q[LOG_QUEUE_SIZE-1:0];

  assign count      = tail_q - head_q;
  assign full       = (count == FULL_CNT);
  assign empty      = (count == '0);
  assign lookup_blk = pr_addr & BLK_MASK;

  // Only the oldest unpromised entry may be claimed, keeping promises in order.
  assign pr_addrHit = (pr_opCode == OP_MASTER) && (prom_q != tail_q) &&
                      (addr_mem[prom_idx] == lookup_blk);

  assign pr_r_valid        = (head_q != prom_q) && (head_q != data_q);
  assign pr_r_in_data      = empty ? '0   : data_mem[head_idx];
  assign pr_r_in_last      = empty ? 1'b0 : last_mem[head_idx];
  assign pr_hasOutstanding = (data_q != tail_q);
  assign prefetchReqCnt    = count;
  assign almostFull        = (count >= AF_THRESH);
  assign protoErr          = err_q;

  // Decode the opcode into pointer moves, write strobes and error flagging.
  always_comb begin
    head_d  = head_q;
    prom_d  = prom_q;
    data_d  = data_q;
    tail_d  = tail_q;
    err_d   = err_q;
    push_we = 1'b0;
    fill_we = 1'b0;
    if (en) begin
      if (!dataFlushN) begin
        head_d = '0;
        prom_d = '0;
        data_d = '0;
        tail_d = '0;
        err_d  = 1'b0;
      end else begin
        case (pr_opCode)
          OP_NOP: begin
          end
          OP_PREF: begin
            if (!full) begin
              push_we = 1'b1;
              tail_d  = tail_q + PTR_ONE;
            end else begin
              err_d = 1'b1;
            end
          end
          OP_MASTER: begin
            // A miss is a normal outcome, not a protocol error.
            if (pr_addrHit) prom_d = prom_q + PTR_ONE;
          end
          OP_SLAVE: begin
            if (data_q != tail_q) begin
              fill_we = 1'b1;
              data_d  = data_q + PTR_ONE;
            end else begin
              err_d = 1'b1;
            end
          end
          OP_PROMISE: begin
            if (pr_r_valid) head_d = head_q + PTR_ONE;
            else            err_d  = 1'b1;
          end
          default: err_d = 1'b1;
        endcase
      end
    end
  end

  // Pointer and error-flag registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      head_q <= '0;
      prom_q <= '0;
      data_q <= '0;
      tail_q <= '0;
      err_q  <= 1'b0;
    end else begin
      head_q <= head_d;
      prom_q <= prom_d;
      data_q <= data_d;
      tail_q <= tail_d;
      err_q  <= err_d;
    end
  end

  // Entry storage writes: block-aligned address at tail, data/last at dataPtr.
  always_ff @(posedge clk) begin
    if (push_we) addr_mem[tail_idx] <= lookup_blk;
    if (fill_we) begin
      data_mem[data_idx] <= pr_r_out_data;
      last_mem[data_idx] <= pr_r_out_last;
    end
  end

endmodule

// File: doc/prefetch_data_queue.md
Name: prefetch_data_queue

Overview:
- Circular promise/data queue directly downstream of the prefetcher controller.
- Consumes the controller's per-cycle opcode stream: prefetch request push, slave-request address lookup, memory data fill, and promised-data pop.
- Returns hit, data-ready, occupancy and back-pressure status to the controller.
- Holds one block per entry: address, last flag, and BLOCK_DATA_SIZE_BITS of data.

Parameters:
- ADDR_BITS, 64, address width.
- LOG_QUEUE_SIZE, 6, log2 of entry count; depth D = 2^LOG_QUEUE_SIZE.
- LOG_BLOCK_DATA_BYTES, 6, log2 of block size in bytes; BLOCK_DATA_SIZE_BITS = 8 << LOG_BLOCK_DATA_BYTES.
- ALMOST_FULL_MARGIN, 2, almostFull asserts when count >= D - ALMOST_FULL_MARGIN.

Ports:
- clk  in  1  clock, rising edge.
- resetN  in  1  asynchronous active-low reset.
- en  in  1  state update enable; when low, all state holds.
- dataFlushN  in  1  synchronous active-low queue clear.
- pr_opCode  in  3  0=nop, 1=readReqPref, 2=readReqMaster, 3=readDataSlave, 4=readDataPromise, 5-7=illegal.
- pr_addr  in  ADDR_BITS  address for opcodes 1 and 2.
- pr_r_out_last  in  1  last flag for opcode 3.
- pr_r_out_data  in  BLOCK_DATA_SIZE_BITS  data for opcode 3.
- pr_addrHit  out  1  combinational; lookup result for opcode 2.
- pr_r_valid  out  1  head entry is promised and filled.
- pr_r_in_last  out  1  head last flag.
- pr_r_in_data  out  BLOCK_DATA_SIZE_BITS  head data.
- pr_hasOutstanding  out  1  at least one entry is awaiting data.
- prefetchReqCnt  out  LOG_QUEUE_SIZE+1  occupied entries, 0..D.
- almostFull  out  1  occupancy at or above threshold.
- protoErr  out  1  sticky flag for illegal operations.

Behaviour:
- Pointers: four pointers of LOG_QUEUE_SIZE+1 bits each (MSB is the wrap bit): head, promPtr, dataPtr, tail.
- Invariants: head <= promPtr <= tail and head <= dataPtr <= tail, in modular order.
- count = tail - head, computed modulo 2^(LOG_QUEUE_SIZE+1).
- full = (count == D); empty = (count == 0).
- Reset: all pointers 0; protoErr 0; memory contents undefined.
  - Resulting outputs: pr_addrHit=0, pr_r_valid=0, pr_r_in_last=0, pr_r_in_data=0, pr_hasOutstanding=0, prefetchReqCnt=0, almostFull=0.
  - Reset mid-operation discards everything immediately.
- Address comparison ignores the low LOG_BLOCK_DATA_BYTES bits (block aligned). Stored addresses are block-aligned on write.
- Opcode 1 (push):
  - If not full: write addr to entry[tail]; tail++.
  - If full: protoErr set, no change.
- Opcode 2 (lookup):
  - pr_addrHit = (promPtr != tail) && blockAddr(entry[promPtr]) == blockAddr(pr_addr).
  - Only the oldest unpromised entry is considered; a match anywhere else is a miss.
  - On hit: promPtr++ at the clock edge.
  - On miss: no state change, no error.
  - pr_addrHit is 0 whenever the opcode is not 2.
- Opcode 3 (fill):
  - If dataPtr != tail: write data/last to entry[dataPtr]; dataPtr++.
  - Otherwise: protoErr set, data dropped.
  - Fills complete in order.
- Opcode 4 (pop):
  - Legal only when pr_r_valid; then head++.
  - Otherwise: protoErr set, no change.
- Illegal opcodes 5-7: protoErr set, no change.
- Status outputs:
  - pr_r_valid = (head != promPtr) && (head != dataPtr).
  - pr_r_in_data and pr_r_in_last come from entry[head] combinationally; they equal 0 when the queue is empty.
  - pr_hasOutstanding = (dataPtr != tail).
  - almostFull = (count >= D - ALMOST_FULL_MARGIN).
- Timing: one opcode per cycle; all status outputs reflect the new state the cycle after the edge that applied the opcode.
- Flush: dataFlushN low with en high sets all four pointers and protoErr to 0 at the edge, regardless of the opcode that cycle.
- en low: opcode and flush are ignored; pr_addrHit is still driven combinationally.
- Wrap-around: pointers wrap modulo 2^(LOG_QUEUE_SIZE+1); full vs empty is distinguished by the MSB.

Test Plan (LOG_QUEUE_SIZE=2, so D=4; LOG_BLOCK_DATA_BYTES=6; ALMOST_FULL_MARGIN=1):
- Basic flow: push 0x1000 -> cnt=1, pr_hasOutstanding=1. Then lookup 0x1020 -> pr_addrHit=1 (same block). Then fill data=0xA5..., last=1 -> pr_r_valid=1, pr_r_in_data=0xA5... Then pop -> cnt=0, pr_r_valid=0.
- Ordering: push 0x1000, 0x1040, 0x1080. Lookup 0x1040 -> pr_addrHit=0, promPtr unchanged. Lookup 0x1000 -> hit; next lookup 0x1040 -> hit.
- Capacity: 3 pushes -> almostFull=1, cnt=3. 4th push -> cnt=4. 5th push -> protoErr=1, cnt stays 4.
- Illegal ops: from reset, pop -> protoErr=1. Fill on empty queue -> protoErr stays 1, cnt=0. Unfilled but promised head -> pr_r_valid=0.
- Wrap-around: 10 full push/lookup/fill/pop rounds -> pointers wrap; data always returned in order; no protoErr.
- Flush and reset: with 3 entries, dataFlushN=0 during a push -> next cycle cnt=0, pr_hasOutstanding=0, protoErr=0. resetN asserted mid-fill -> all outputs 0 immediately.
